// File: rtl/nice_line_framer_if.sv
// Byte-stream handshake bundle for the line framer: raw input side and framed line output side.
// The framer takes the slave view; the byte source / line consumer takes the master view.
interface nice_line_framer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_empty;
    logic       out_trunc;
    logic       out_eof;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  out_empty,
        input  out_trunc,
        input  out_eof
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last,
        output out_empty,
        output out_trunc,
        output out_eof
    );
endinterface

// File: rtl/nice_line_framer.sv
// Splits a byte stream into lines on LF, CR and CRLF, buffers one line and replays it
// as a framed burst with empty/trunc/eof markers on the last beat.
module nice_line_framer #(
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nice_line_framer_if.slave    bus,
    output logic [CNT_W-1:0]     line_count,
    output logic                 busy
);

    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned CW = AW + 1;

    localparam logic [7:0] ByteLf = 8'h0A;
    localparam logic [7:0] ByteCr = 8'h0D;

    typedef enum logic [0:0] {StFill, StDrain} state_e;

    state_e           st_q, st_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic             prev_cr_q, prev_cr_d;
    logic             trunc_q, trunc_d;
    logic             eof_q, eof_d;
    logic [CNT_W-1:0] line_count_q, line_count_d;

    logic [7:0]       line_mem [MAX_LEN];

    logic             is_lf;
    logic             is_cr;
    logic             term;
    logic             wr_en;
    logic             drain;
    logic             line_empty;
    logic             last_beat;

    assign is_lf      = (bus.in_data == ByteLf);
    assign is_cr      = (bus.in_data == ByteCr);
    assign drain      = (st_q == StDrain);
    assign line_empty = (count_q == '0);
    assign last_beat  = line_empty || ({1'b0, rd_q} == (count_q - CW'(1)));

    always_comb begin
        st_d         = st_q;
        count_d      = count_q;
        rd_d         = rd_q;
        prev_cr_d    = prev_cr_q;
        trunc_d      = trunc_q;
        eof_d        = eof_q;
        line_count_d = line_count_q;
        term         = 1'b0;
        wr_en        = 1'b0;

        unique case (st_q)
            StFill: begin
                if (bus.in_valid) begin
                    if (is_lf && prev_cr_q) begin
                        // Second half of CRLF: the CR already ended the line.
                        prev_cr_d = 1'b0;
                    end else if (is_lf) begin
                        term = 1'b1;
                    end else if (is_cr) begin
                        term      = 1'b1;
                        prev_cr_d = 1'b1;
                    end else begin
                        wr_en     = 1'b1;
                        count_d   = count_q + CW'(1);
                        prev_cr_d = 1'b0;
                        if (count_q == CW'(MAX_LEN - 1)) begin
                            term    = 1'b1;
                            trunc_d = 1'b1;
                        end
                    end

                    if (bus.in_last) begin
                        term      = 1'b1;
                        eof_d     = 1'b1;
                        prev_cr_d = 1'b0;
                    end

                    if (term) begin
                        st_d = StDrain;
                        rd_d = '0;
                    end
                end
            end

            StDrain: begin
                if (bus.out_ready) begin
                    if (last_beat) begin
                        st_d         = StFill;
                        count_d      = '0;
                        trunc_d      = 1'b0;
                        eof_d        = 1'b0;
                        line_count_d = line_count_q + CNT_W'(1);
                    end else begin
                        rd_d = rd_q + AW'(1);
                    end
                end
            end

            default: begin
                st_d = StFill;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= StFill;
            count_q      <= '0;
            rd_q         <= '0;
            prev_cr_q    <= 1'b0;
            trunc_q      <= 1'b0;
            eof_q        <= 1'b0;
            line_count_q <= '0;
        end else begin
            st_q         <= st_d;
            count_q      <= count_d;
            rd_q         <= rd_d;
            prev_cr_q    <= prev_cr_d;
            trunc_q      <= trunc_d;
            eof_q        <= eof_d;
            line_count_q <= line_count_d;
        end
    end

    // Line storage carries no reset; only bytes below count are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[count_q[AW-1:0]] <= bus.in_data;
        end
    end

    assign bus.in_ready  = !drain;
    assign bus.out_valid = drain;
    assign bus.out_data  = (drain && !line_empty) ? line_mem[rd_q] : 8'h00;
    assign bus.out_last  = drain && last_beat;
    assign bus.out_empty = drain && line_empty;
    assign bus.out_trunc = drain && last_beat && trunc_q;
    assign bus.out_eof   = drain && last_beat && eof_q;
    assign busy          = drain;
    assign line_count    = line_count_q;

endmodule

// File: doc/nice_line_framer.md
# nice_line_framer

Hardware counterpart of the `io` line-reading facilities. It consumes a raw byte stream, such as a DPI/testbench byte source or a UART receive stage, and splits it into lines on `"\n"`, `"\r"` and `"\r\n"` terminators. Each line is emitted as a framed byte burst for a downstream log or command parser. The block sits directly downstream of the byte-level stream source and buffers one line at a time.

## Interface
Parameters:
- `MAX_LEN`, 64: line buffer depth in bytes. Must be a power of 2 and at least 2.
- `CNT_W`, 16: width of the `line_count` counter.

Ports:
- `clk`, input, 1: the single clock. All logic is on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: an input byte is offered.
- `in_ready`, output, 1: the block accepts the input byte this cycle.
- `in_data`, input, 8: input byte.
- `in_last`, input, 1: marks the final byte of the stream.
- `out_valid`, output, 1: an output beat is offered.
- `out_ready`, input, 1: the consumer accepts the output beat.
- `out_data`, output, 8: line byte. Reads as 0 on an empty-line beat.
- `out_last`, output, 1: final beat of the current line.
- `out_empty`, output, 1: the line has zero bytes. Only asserted together with `out_last`.
- `out_trunc`, output, 1: the line was cut at `MAX_LEN` bytes. Only meaningful on the last beat.
- `out_eof`, output, 1: this line ends the stream. Only meaningful on the last beat.
- `line_count`, output, `CNT_W`: number of lines emitted. Wraps modulo 2^`CNT_W`.
- `busy`, output, 1: the block is in the DRAIN state.

## Operation
- Two states: FILL and DRAIN. Reset enters FILL and clears the byte count, the read pointer, `prev_cr`, the trunc and eof flags, and `line_count`.
- Output reset values: `in_ready`=1, `out_valid`=0, `out_last`=0, `out_empty`=0, `out_trunc`=0, `out_eof`=0, `out_data`=0, `line_count`=0, `busy`=0.
- FILL state:
  - `in_ready`=1 and `out_valid`=0.
  - Accept when `in_valid` is high. Classify the byte as follows:
    - LF with `prev_cr`=1: drop the byte and clear `prev_cr`. The line does not terminate; this is the second half of a CRLF. If `in_last` is set, terminate as eof, which yields an empty line only if the count is 0.
    - LF with `prev_cr`=0: terminate the line.
    - CR: terminate the line and set `prev_cr`=1.
    - Any other byte: write it to `buf[count]`, increment `count`, clear `prev_cr`. If the new count equals `MAX_LEN`, terminate with trunc=1.
  - `in_last` on an accepted byte sets eof=1 and forces termination after the byte is handled. A terminator byte carrying `in_last` produces exactly one line, not an extra empty line.
  - Termination: move to DRAIN and set the read pointer to 0. The terminator byte is never stored or emitted.
- DRAIN state:
  - `in_ready`=0 and `busy`=1. `out_valid`=1 and `out_data`=`buf[rd]`.
  - `out_last` = (count==0) or (rd==count−1). `out_empty` = (count==0).
  - `out_trunc` and `out_eof` show the latched flags on the last beat and read 0 on other beats.
  - On `out_valid && out_ready`: if not the last beat, increment `rd`. If the last beat, go to FILL, clear count, trunc and eof, and increment `line_count` (wrapping).
  - Output stalls hold every out_* signal stable.
- `prev_cr` persists across the DRAIN state. A CR-terminated line followed by an LF as the next input drops that LF.
- After a truncated line, the remaining bytes start a new line. A terminator arriving right after truncation ends a genuine empty line.
- After an eof line, the block returns to FILL and accepts a new stream. `prev_cr` is cleared at eof.
- A `rst` assertion while in DRAIN aborts the line immediately. No further beats of that line are emitted.

## Timing
- Terminator accepted in cycle N gives `out_valid`=1 in cycle N+1 with the first byte. The `buf` read is combinational from registered `rd`.
- A line of L bytes takes L output cycles with `out_ready` held high, or 1 cycle if L=0. The first FILL accept follows in the cycle after the last handshake.
- Throughput with no stalls: one input byte per cycle in FILL and one output byte per cycle in DRAIN. There is no overlap between the two states.
- `line_count` updates in the cycle after the last-beat handshake.

## Test plan
- Input "AB\nC\n" with `out_ready`=1: bursts are "AB", with `out_last` on B, then "C". `line_count`=2. `out_valid` rises 1 cycle after each LF is accepted.
- Input "X\r\nY\r" with `in_last` on the final CR: lines are "X" and then "Y" with `out_eof`=1. There is no empty line from the CRLF. `line_count`=2.
- Input "\n\n": two beats, each with `out_empty`=1, `out_last`=1 and `out_data`=0. `line_count`=2.
- `MAX_LEN`=4 with input "ABCDEF\n": "ABCD" with `out_trunc`=1 on D, then "EF" with `out_trunc`=0.
- Line "HELLO\n" with `out_ready` toggling 1,0,0,1,…: bytes arrive in order and stay stable during stalls. `in_ready`=0 for the whole DRAIN. `line_count` wraps from 0xFFFF to 0 with `CNT_W`=16 and the counter preloaded by forcing.
- Assert `rst` on the third output beat of "ABCDE": next cycle `out_valid`=0, `in_ready`=1 and `line_count`=0. The following input "Z\n" emits "Z" only.
